// File: rtl/sa_operand_serializer.sv
// -----------------------------------------------------------------------------
// sa_operand_serializer
// Feeds the serial adder. Parallel operand pairs are accepted over a
// valid/ready handshake into a small FIFO, then each pair is replayed as one
// serial frame on en_i/ina/inb (WIDTH cycles with en_i high), followed by a
// fixed idle gap of GAP_CYCLES cycles so the adder can drain its result.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     FIFO can accept (not full), from registered count only
//   in_a, in_b   operands, WIDTH bits each
//   flush        synchronous discard of all FIFO contents
//   en_i         serial frame enable to the adder (registered)
//   ina, inb     serial operand bits (registered, 0 while en_i is low)
//   busy         high while a frame or its trailing gap is in progress
//   fifo_count   number of stored operand pairs (0..DEPTH)
//   frames_sent  completed-frame counter, wraps at 16 bits
//
// rst_n is expected to be release-synchronised to clk upstream.
// -----------------------------------------------------------------------------
module sa_operand_serializer #(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 3,
    parameter int MSB_FIRST  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       flush,
    output logic                       en_i,
    output logic                       ina,
    output logic                       inb,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [15:0]                frames_sent
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Bit that leaves the shifter first for the configured bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 32'sd0) begin
            first_bit = v[WIDTH-1];
        end else begin
            first_bit = v[0];
        end
    endfunction

    // Shifter contents after one bit has been sent.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 32'sd0) begin
            advance = v << 1'b1;
        end else begin
            advance = v >> 1'b1;
        end
    endfunction

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_mem [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_sh_a;
    logic [WIDTH-1:0]     r_sh_b;
    logic [BW-1:0]        r_bit_idx;
    logic [GW-1:0]        r_gap_cnt;
    logic                 r_en_i;
    logic                 r_ina;
    logic                 r_inb;
    logic [15:0]          r_frames;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_bit;
    logic                 w_last_gap;
    logic [2*WIDTH-1:0]   w_rd_word;
    logic [WIDTH-1:0]     w_rd_a;
    logic [WIDTH-1:0]     w_rd_b;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == CW'(0));
    // A push coinciding with flush is dropped.
    assign w_push     = in_valid && !w_full && !flush;
    assign w_last_bit = (r_state == S_SHIFT) && (r_bit_idx == BW'(WIDTH - 1));
    assign w_last_gap = (r_state == S_GAP) && (r_gap_cnt == GW'(GAP_CYCLES - 1));
    assign w_rd_word  = r_mem[r_rd_ptr];
    assign w_rd_a     = w_rd_word[2*WIDTH-1:WIDTH];
    assign w_rd_b     = w_rd_word[WIDTH-1:0];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and pop decision; flush cancels a pop due on the same edge.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !flush) begin
                    w_next = S_SHIFT;
                    w_pop  = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_last_bit) begin
                    w_next = S_GAP;
                end else begin
                    w_next = S_SHIFT;
                end
            end
            S_GAP: begin
                if (w_last_gap) begin
                    if (!w_empty && !flush) begin
                        w_next = S_SHIFT;
                        w_pop  = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else begin
                    w_next = S_GAP;
                end
            end
            default: begin
                w_next = S_IDLE;
                w_pop  = 1'b0;
            end
        endcase
    end

    // FIFO storage; data words need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
            r_count  <= CW'(0);
        end else if (flush) begin
            r_wr_ptr <= PW'(0);
            r_rd_ptr <= PW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Serial datapath: the popped word's first bit is driven on the pop edge,
    // the shifters hold the bits still to be sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_i    <= 1'b0;
            r_ina     <= 1'b0;
            r_inb     <= 1'b0;
            r_sh_a    <= WIDTH'(0);
            r_sh_b    <= WIDTH'(0);
            r_bit_idx <= BW'(0);
        end else if (w_pop) begin
            r_en_i    <= 1'b1;
            r_ina     <= first_bit(w_rd_a);
            r_inb     <= first_bit(w_rd_b);
            r_sh_a    <= advance(w_rd_a);
            r_sh_b    <= advance(w_rd_b);
            r_bit_idx <= BW'(0);
        end else if ((r_state == S_SHIFT) && !w_last_bit) begin
            r_en_i    <= 1'b1;
            r_ina     <= first_bit(r_sh_a);
            r_inb     <= first_bit(r_sh_b);
            r_sh_a    <= advance(r_sh_a);
            r_sh_b    <= advance(r_sh_b);
            r_bit_idx <= r_bit_idx + BW'(1);
        end else begin
            r_en_i    <= 1'b0;
            r_ina     <= 1'b0;
            r_inb     <= 1'b0;
        end
    end

    // Gap timer and completed-frame counter, both keyed off the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= GW'(0);
            r_frames  <= 16'd0;
        end else if (w_last_bit) begin
            r_gap_cnt <= GW'(0);
            r_frames  <= r_frames + 16'd1;
        end else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
        end else begin
            r_gap_cnt <= r_gap_cnt;
        end
    end

    assign in_ready    = !w_full;
    assign en_i        = r_en_i;
    assign ina         = r_ina;
    assign inb         = r_inb;
    assign busy        = (r_state != S_IDLE);
    assign fifo_count  = r_count;
    assign frames_sent = r_frames;

endmodule

// File: tb/tb_sa_operand_serializer.sv
// Scoreboard bench: stimulus pushes expected frames into per-instance queues,
// negedge monitors rebuild each serial frame and compare against the queue.
module tb_sa_operand_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;

    // Instance 0: default parameters (WIDTH=2, MSB first)
    logic        in_valid0 = 1'b0, flush0 = 1'b0;
    logic [1:0]  in_a0 = 2'b00, in_b0 = 2'b00;
    logic        in_ready0, en_i0, ina0, inb0, busy0;
    logic [2:0]  cnt0;
    logic [15:0] fs0;

    // Instance 1: WIDTH=4, LSB first
    logic        in_valid1 = 1'b0, flush1 = 1'b0;
    logic [3:0]  in_a1 = 4'b0000, in_b1 = 4'b0000;
    logic        in_ready1, en_i1, ina1, inb1, busy1;
    logic [2:0]  cnt1;
    logic [15:0] fs1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] q0[$];
    logic [7:0] q1[$];
    int         rise0[$];

    sa_operand_serializer #(.WIDTH(2), .DEPTH(4), .GAP_CYCLES(3), .MSB_FIRST(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a0), .in_b(in_b0), .flush(flush0), .en_i(en_i0), .ina(ina0),
        .inb(inb0), .busy(busy0), .fifo_count(cnt0), .frames_sent(fs0)
    );

    sa_operand_serializer #(.WIDTH(4), .DEPTH(4), .GAP_CYCLES(5), .MSB_FIRST(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .flush(flush1), .en_i(en_i1), .ina(ina1),
        .inb(inb1), .busy(busy1), .fifo_count(cnt1), .frames_sent(fs1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for instance 0: MSB-first, 2-bit frames
    int         b0 = 0;
    logic [1:0] acc_a0 = 2'b00, acc_b0 = 2'b00;
    logic [3:0] cur0 = 4'h0;
    bit         have0 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            b0 = 0;
            have0 = 1'b0;
        end else if (en_i0) begin
            if (b0 == 0) begin
                rise0.push_back(cyc);
                if (q0.size() == 0) begin
                    chk("frame0_unexpected", 32'd1, 32'd0);
                    have0 = 1'b0;
                end else begin
                    cur0 = q0.pop_front();
                    have0 = 1'b1;
                end
            end
            acc_a0 = {acc_a0[0], ina0};
            acc_b0 = {acc_b0[0], inb0};
            b0++;
            if (b0 == 2) begin
                if (have0) chk("frame0_data", 32'({acc_a0, acc_b0}), 32'(cur0));
                b0 = 0;
            end
        end else begin
            if (b0 != 0) begin
                chk("frame0_short", 32'(b0), 32'd2);
                b0 = 0;
            end
            chk("idle0_bits_zero", 32'({ina0, inb0}), 32'd0);
        end
    end

    // Monitor for instance 1: LSB-first, 4-bit frames
    int         b1 = 0;
    logic [3:0] acc_a1 = 4'h0, acc_b1 = 4'h0;
    logic [7:0] cur1 = 8'h00;
    bit         have1 = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            b1 = 0;
            have1 = 1'b0;
        end else if (en_i1) begin
            if (b1 == 0) begin
                acc_a1 = 4'h0;
                acc_b1 = 4'h0;
                if (q1.size() == 0) begin
                    chk("frame1_unexpected", 32'd1, 32'd0);
                    have1 = 1'b0;
                end else begin
                    cur1 = q1.pop_front();
                    have1 = 1'b1;
                end
            end
            acc_a1[b1] = ina1;
            acc_b1[b1] = inb1;
            b1++;
            if (b1 == 4) begin
                if (have1) chk("frame1_data", 32'({acc_a1, acc_b1}), 32'(cur1));
                b1 = 0;
            end
        end else begin
            if (b1 != 0) begin
                chk("frame1_short", 32'(b1), 32'd4);
                b1 = 0;
            end
            chk("idle1_bits_zero", 32'({ina1, inb1}), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle0(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (!busy0 && cnt0 == 3'd0) done = 1'b1;
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    task automatic wait_idle1(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (!busy1 && cnt1 == 3'd0) done = 1'b1;
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    task automatic push0(input logic [1:0] a, input logic [1:0] b);
        in_valid0 = 1'b1;
        in_a0 = a;
        in_b0 = b;
        chk("push0_ready", 32'(in_ready0), 32'd1);
        q0.push_back({a, b});
        tick();
        in_valid0 = 1'b0;
    endtask

    task automatic push1(input logic [3:0] a, input logic [3:0] b);
        in_valid1 = 1'b1;
        in_a1 = a;
        in_b1 = b;
        chk("push1_ready", 32'(in_ready1), 32'd1);
        q1.push_back({a, b});
        tick();
        in_valid1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [1:0] kk;
        logic [3:0] ea, eb;

        // 1. reset defaults
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en_i", 32'(en_i0), 32'd0);
        chk("rst_inab", 32'({ina0, inb0}), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_frames", 32'(fs0), 32'd0);
        chk("rst_ready", 32'(in_ready0), 32'd1);
        chk("rst_ready1", 32'(in_ready1), 32'd1);
        rst_n = 1'b1;
        repeat (2) tick();

        // 2. single frame, latency and gap timing
        push0(2'b10, 2'b11);
        chk("t2_en_after_push", 32'(en_i0), 32'd0);
        chk("t2_count_after_push", 32'(cnt0), 32'd1);
        tick();
        chk("t2_bit1", 32'({en_i0, ina0, inb0}), 32'b111);
        chk("t2_busy", 32'(busy0), 32'd1);
        chk("t2_count_popped", 32'(cnt0), 32'd0);
        tick();
        chk("t2_bit2", 32'({en_i0, ina0, inb0}), 32'b101);
        tick();
        chk("t2_gap_en", 32'(en_i0), 32'd0);
        chk("t2_frames", 32'(fs0), 32'd1);
        tick();
        tick();
        chk("t2_gap_busy", 32'(busy0), 32'd1);
        tick();
        chk("t2_idle_busy", 32'(busy0), 32'd0);
        tick();

        // 3. streaming until full: 5 of 6 accepted, period WIDTH+GAP
        rise0.delete();
        t0 = 0;
        in_valid0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            kk = 2'(k);
            in_a0 = kk;
            in_b0 = ~kk;
            chk("t3_ready", 32'(in_ready0), (k < 5) ? 32'd1 : 32'd0);
            if (in_ready0) q0.push_back({kk, ~kk});
            tick();
            if (k == 0) t0 = cyc;
        end
        in_valid0 = 1'b0;
        wait_idle0("t3_idle_timeout");
        chk("t3_frames", 32'(fs0), 32'd6);
        chk("t3_nframes", 32'(rise0.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rise0.size()) chk("t3_rise_cycle", 32'(rise0[i]), 32'(t0 + 1 + 5 * i));
        end

        // 4a. flush during the first frame's 2nd bit, with a push in the flush cycle
        push0(2'b01, 2'b01);
        push0(2'b10, 2'b00);
        push0(2'b11, 2'b10);
        in_valid0 = 1'b1;
        in_a0 = 2'b11;
        in_b0 = 2'b11;
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        in_valid0 = 1'b0;
        q0.delete();
        chk("t4_count_flushed", 32'(cnt0), 32'd0);
        chk("t4_frame_done", 32'(fs0), 32'd7);
        chk("t4_in_gap", 32'(busy0), 32'd1);
        wait_idle0("t4_idle_timeout");
        repeat (8) tick();
        chk("t4_no_more_frames", 32'(fs0), 32'd7);

        // 4b. flush on the last gap edge cancels the pending pop
        push0(2'b11, 2'b01);
        push0(2'b00, 2'b10);
        repeat (4) tick();
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        q0.delete();
        chk("t4b_count", 32'(cnt0), 32'd0);
        chk("t4b_pop_cancelled", 32'(busy0), 32'd0);
        chk("t4b_en", 32'(en_i0), 32'd0);
        repeat (8) tick();
        chk("t4b_frames", 32'(fs0), 32'd8);

        // 5. reset asserted during the 2nd bit of a frame
        in_valid0 = 1'b1;
        in_a0 = 2'b11;
        in_b0 = 2'b11;
        q0.push_back(4'b1111);
        tick();
        in_a0 = 2'b01;
        tick();
        in_valid0 = 1'b0;
        chk("t5_bit1_en", 32'(en_i0), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", 32'({en_i0, ina0, inb0}), 32'd0);
        chk("t5_rst_count", 32'(cnt0), 32'd0);
        chk("t5_rst_busy", 32'(busy0), 32'd0);
        chk("t5_rst_frames", 32'(fs0), 32'd0);
        q0.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t5_no_resume", 32'(en_i0), 32'd0);
        chk("t5_frames_after", 32'(fs0), 32'd0);
        push0(2'b01, 2'b10);
        wait_idle0("t5_idle_timeout");
        chk("t5_new_frame", 32'(fs0), 32'd1);

        // 6. WIDTH=4, LSB first
        ea = 4'b0001;
        eb = 4'b1000;
        push1(ea, eb);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_bits", 32'({en_i1, ina1, inb1}), 32'({1'b1, ea[i], eb[i]}));
        end
        tick();
        chk("t6_gap_en", 32'(en_i1), 32'd0);
        push1(4'b1011, 4'b0110);
        wait_idle1("t6_idle_timeout");
        chk("t6_frames", 32'(fs1), 32'd2);

        tick();
        chk("end_q0_empty", 32'(q0.size()), 32'd0);
        chk("end_q1_empty", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sa_operand_serializer.md
Name: sa_operand_serializer

Overview:
Upstream feeder for the serial adder. Accepts parallel operand pairs over a valid/ready handshake and buffers them in a small FIFO. Converts each pair into the adder's serial input frame on en_i/ina/inb. Inserts a mandatory idle gap between frames so the adder has time to emit its WIDTH+1-bit serial result on en_o/out.

Parameters:
WIDTH, 2, operand width in bits; also the frame length in cycles (en_i high time)
DEPTH, 4, operand FIFO depth in entries (power of two, >=2)
GAP_CYCLES, 3, minimum cycles with en_i low between frames (>=1; default WIDTH+1)
MSB_FIRST, 1, 1 = MSB of each operand sent first, 0 = LSB first

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept; equals !full, derived from registered count only
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
flush  in  1  synchronous; discard all FIFO contents
en_i  out  1  serial frame enable to adder, registered
ina  out  1  serial bit of A, registered
inb  out  1  serial bit of B, registered
busy  out  1  1 while in SHIFT or GAP
fifo_count  out  $clog2(DEPTH+1)  entries stored
frames_sent  out  16  completed-frame counter, wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync release): en_i=ina=inb=0, busy=0, fifo_count=0, frames_sent=0, in_ready=1, FSM=IDLE. FIFO pointers cleared. Assertion mid-frame drops en_i/ina/inb to 0 immediately; the aborted frame never resumes.
- Push: in_valid && in_ready at a posedge writes {in_a,in_b}. in_valid while in_ready=0 is ignored; no overflow and no count change.
- Pop occurs at the posedge where the FSM is IDLE (or on the last GAP cycle) and the FIFO is non-empty. The popped word loads the shift registers. The first bits appear on en_i/ina/inb immediately after that edge.
- Latency: a word pushed at edge T into an empty FIFO with an IDLE FSM gives en_i=1 from edge T+1.
- FSM:
  - IDLE: en_i=0. If FIFO non-empty -> SHIFT (pop).
  - SHIFT: en_i=1 for exactly WIDTH cycles. ina/inb carry bit WIDTH-1 down to 0 (MSB_FIRST=1) or 0 up to WIDTH-1. On the edge ending the last bit: frames_sent++ and -> GAP.
  - GAP: en_i=0, ina=inb=0 for exactly GAP_CYCLES cycles. On the edge ending the last gap cycle: if FIFO non-empty -> SHIFT (pop), else -> IDLE.
- Back-to-back frame period is exactly WIDTH+GAP_CYCLES cycles. en_i never stays high longer than WIDTH cycles.
- ina/inb are 0 whenever en_i=0.
- Simultaneous push and pop: count unchanged; both take effect.
- Full: in_ready=0 for the whole cycle, even if a pop happens that edge; it rises the cycle after.
- Empty: no pop; FSM stays IDLE.
- flush:
  - Sets fifo_count=0 and clears the pointers at the next edge.
  - A push in the same cycle is dropped.
  - A frame already in SHIFT completes normally, including its GAP.
  - A pop scheduled at the same edge is cancelled.
- FIFO pointers wrap modulo DEPTH. Count ranges over 0..DEPTH.

Test Plan:
1. Reset, defaults (WIDTH=2, DEPTH=4, GAP_CYCLES=3, MSB_FIRST=1) -> all outputs 0, in_ready=1, busy=0.
2. Push a=2'b10, b=2'b11 at edge T -> en_i=1 in cycles T+1..T+2; ina=1,0; inb=1,1; en_i=0 in T+3..T+5; frames_sent=1 after edge T+3; busy=0 from T+6.
3. Hold in_valid with 6 consecutive words from T0 -> exactly 5 accepted (T0..T4), in_ready=0 at T5. Frames rise on en_i at T1, T6, T11, T16, T21; data emitted in push order; frames_sent=5.
4. Queue 3 words, assert flush during the first frame's 2nd bit -> the first frame completes; fifo_count=0 next cycle; no further frames; frames_sent=1.
5. Deassert rst_n during the 2nd bit of a frame -> en_i/ina/inb=0 combinationally from the reset edge; count=0. After release, en_i stays 0 until a new push.
6. WIDTH=4, MSB_FIRST=0, a=4'b0001, b=4'b1000 -> ina=1,0,0,0 and inb=0,0,0,1 over 4 en_i cycles.
